// File: rtl/hex_scan_ctrl.sv
// Multiplexed 7-segment hex display scanner with a one-deep pending buffer, so a new value
// is swapped in only at frame end, and optional leading-zero blanking.
module hex_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned DIV        = 50000
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [4*NUM_DIGITS-1:0] data_i,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic                    en_i,
    input  logic                    blank_lz_i,
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   an_o
);

    localparam int unsigned DigW = $clog2(NUM_DIGITS);
    localparam int unsigned CntW = $clog2(DIV);
    localparam logic [DigW-1:0] LastDig = DigW'(NUM_DIGITS - 1);
    localparam logic [CntW-1:0] LastCnt = CntW'(DIV - 1);

    typedef enum logic [0:0] {StIdle, StScan} state_e;

    state_e                  state_q, state_d;
    logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
    logic [4*NUM_DIGITS-1:0] pend_q, pend_d;
    logic                    pend_vld_q, pend_vld_d;
    logic                    have_data_q, have_data_d;
    logic [DigW-1:0]         digit_q, digit_d;
    logic [CntW-1:0]         cnt_q, cnt_d;

    logic                    load;
    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    zero_run;
    logic [3:0]              nib;
    logic                    blank;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h58;
            4'h8: s = 7'h00;
            4'h9: s = 7'h18;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            have_data_q <= 1'b0;
            digit_q     <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            have_data_q <= have_data_d;
            digit_q     <= digit_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        disp_d      = disp_q;
        pend_d      = pend_q;
        pend_vld_d  = pend_vld_q;
        have_data_d = have_data_q;
        digit_d     = digit_q;
        cnt_d       = cnt_q;
        load        = valid_i && ready_o;
        unique case (state_q)
            StIdle: begin
                digit_d = '0;
                cnt_d   = '0;
                if (load) begin
                    disp_d      = data_i;
                    have_data_d = 1'b1;
                end
                if (en_i && have_data_q) begin
                    state_d = StScan;
                end
            end
            StScan: begin
                if (!en_i) begin
                    state_d = StIdle;
                    digit_d = '0;
                    cnt_d   = '0;
                end else if (cnt_q == LastCnt) begin
                    cnt_d = '0;
                    if (digit_q == LastDig) begin
                        digit_d = '0;
                        // Swap only at frame end so a frame never mixes old and new digits.
                        if (pend_vld_q) begin
                            disp_d     = pend_q;
                            pend_vld_d = 1'b0;
                        end
                    end else begin
                        digit_d = digit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (load) begin
                    pend_d     = data_i;
                    pend_vld_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // lz_mask[k] is set when nibbles k..top are all zero; digit 0 is never masked.
    always_comb begin
        zero_run = 1'b1;
        lz_mask  = '0;
        for (int k = int'(NUM_DIGITS) - 1; k > 0; k--) begin
            zero_run   = zero_run && (disp_q[4*k +: 4] == 4'h0);
            lz_mask[k] = zero_run;
        end
    end

    always_comb begin
        an_o    = '1;
        seg_o   = 7'h7F;
        ready_o = 1'b1;
        nib     = 4'h0;
        blank   = 1'b0;
        if (state_q == StScan) begin
            ready_o = !pend_vld_q;
            for (int k = 0; k < int'(NUM_DIGITS); k++) begin
                if (digit_q == DigW'(k)) begin
                    nib   = disp_q[4*k +: 4];
                    blank = blank_lz_i && lz_mask[k];
                    if (!blank) begin
                        an_o[k] = 1'b0;
                    end
                end
            end
            if (!blank) begin
                seg_o = hex_to_seg(nib);
            end
        end
    end

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed bench for hex_scan_ctrl with 4 digits and a 4-cycle prescaler.
module tb_hex_scan_ctrl;

    logic        clk_i      = 1'b0;
    logic        rst_ni     = 1'b0;
    logic [15:0] data_i     = 16'h0;
    logic        valid_i    = 1'b0;
    logic        en_i       = 1'b0;
    logic        blank_lz_i = 1'b0;
    logic        ready_o;
    logic [6:0]  seg_o;
    logic [3:0]  an_o;

    int pass_cnt  = 0;
    int total_cnt = 0;

    hex_scan_ctrl #(
        .NUM_DIGITS(4),
        .DIV       (4)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .en_i      (en_i),
        .blank_lz_i(blank_lz_i),
        .seg_o     (seg_o),
        .an_o      (an_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        #2;
        total_cnt++;
        if (an_o !== 4'hF) $display("FAIL reset_an: got %h want F", an_o); else pass_cnt++;
        total_cnt++;
        if (seg_o !== 7'h7F) $display("FAIL reset_seg: got %h want 7F", seg_o); else pass_cnt++;
        total_cnt++;
        if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready_o); else pass_cnt++;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step();
    endtask

    task automatic test_scan();
        logic [3:0] an_exp [4];
        logic [6:0] seg_exp [4];
        an_exp  = '{4'hE, 4'hD, 4'hB, 4'h7};
        seg_exp = '{7'h19, 7'h30, 7'h24, 7'h79};
        data_i  = 16'h1234;
        valid_i = 1'b1;
        en_i    = 1'b1;
        step();
        valid_i = 1'b0;
        total_cnt++;
        if (an_o !== 4'hF) $display("FAIL scan_idle_after_load: got %h want F", an_o);
        else pass_cnt++;
        step();
        for (int i = 0; i < 16; i++) begin
            total_cnt++;
            if (an_o !== an_exp[i/4])
                $display("FAIL scan_an[%0d]: got %h want %h", i, an_o, an_exp[i/4]);
            else pass_cnt++;
            total_cnt++;
            if (seg_o !== seg_exp[i/4])
                $display("FAIL scan_seg[%0d]: got %h want %h", i, seg_o, seg_exp[i/4]);
            else pass_cnt++;
            step();
        end
        total_cnt++;
        if (an_o !== 4'hE) $display("FAIL scan_wrap_an: got %h want E", an_o); else pass_cnt++;
    endtask

    task automatic test_blank();
        logic [3:0] an_exp [4];
        logic [6:0] seg_exp [4];
        an_exp  = '{4'hE, 4'hD, 4'hF, 4'hF};
        seg_exp = '{7'h40, 7'h12, 7'h7F, 7'h7F};
        en_i = 1'b0;
        step();
        blank_lz_i = 1'b1;
        data_i     = 16'h0050;
        valid_i    = 1'b1;
        step();
        valid_i = 1'b0;
        en_i    = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            total_cnt++;
            if (an_o !== an_exp[i/4])
                $display("FAIL blank_an[%0d]: got %h want %h", i, an_o, an_exp[i/4]);
            else pass_cnt++;
            total_cnt++;
            if (seg_o !== seg_exp[i/4])
                $display("FAIL blank_seg[%0d]: got %h want %h", i, seg_o, seg_exp[i/4]);
            else pass_cnt++;
            if (i == 9) begin
                blank_lz_i = 1'b0;
                #1;
                total_cnt++;
                if (an_o !== 4'hB || seg_o !== 7'h40)
                    $display("FAIL blank_comb_off: got an=%h seg=%h want an=B seg=40",
                             an_o, seg_o);
                else pass_cnt++;
                blank_lz_i = 1'b1;
                #1;
            end
            step();
        end
        en_i = 1'b0;
        step();
        data_i  = 16'h0000;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        en_i    = 1'b1;
        step();
        for (int i = 0; i < 16; i++) begin
            total_cnt++;
            if (an_o !== ((i < 4) ? 4'hE : 4'hF) || seg_o !== ((i < 4) ? 7'h40 : 7'h7F))
                $display("FAIL blank_zero[%0d]: got an=%h seg=%h", i, an_o, seg_o);
            else pass_cnt++;
            step();
        end
    endtask

    task automatic test_pending();
        en_i       = 1'b0;
        blank_lz_i = 1'b0;
        step();
        data_i  = 16'h1234;
        valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        en_i    = 1'b1;
        step();
        repeat (5) step();
        total_cnt++;
        if (ready_o !== 1'b1 || an_o !== 4'hD)
            $display("FAIL pend_before: got ready=%b an=%h want ready=1 an=D", ready_o, an_o);
        else pass_cnt++;
        data_i  = 16'hABCD;
        valid_i = 1'b1;
        step();
        total_cnt++;
        if (ready_o !== 1'b0) $display("FAIL pend_ready_drop: got %b want 0", ready_o);
        else pass_cnt++;
        total_cnt++;
        if (seg_o !== 7'h30) $display("FAIL pend_old_digit1: got %h want 30", seg_o);
        else pass_cnt++;
        data_i = 16'h5555;
        step();
        valid_i = 1'b0;
        for (int i = 7; i <= 28; i++) begin
            if (i == 15) begin
                total_cnt++;
                if (an_o !== 4'h7 || seg_o !== 7'h79 || ready_o !== 1'b0)
                    $display("FAIL pend_old_digit3: got an=%h seg=%h ready=%b want 7/79/0",
                             an_o, seg_o, ready_o);
                else pass_cnt++;
            end
            if (i == 16) begin
                total_cnt++;
                if (an_o !== 4'hE || seg_o !== 7'h21 || ready_o !== 1'b1)
                    $display("FAIL pend_new_digit0: got an=%h seg=%h ready=%b want E/21/1",
                             an_o, seg_o, ready_o);
                else pass_cnt++;
            end
            if (i == 20) begin
                total_cnt++;
                if (seg_o !== 7'h46) $display("FAIL pend_digit1: got %h want 46", seg_o);
                else pass_cnt++;
            end
            if (i == 24) begin
                total_cnt++;
                if (seg_o !== 7'h03) $display("FAIL pend_digit2: got %h want 03", seg_o);
                else pass_cnt++;
            end
            if (i == 28) begin
                total_cnt++;
                if (seg_o !== 7'h08) $display("FAIL pend_digit3: got %h want 08", seg_o);
                else pass_cnt++;
            end
            step();
        end
    endtask

    task automatic test_disable();
        en_i = 1'b0;
        total_cnt++;
        if (an_o !== 4'h7) $display("FAIL dis_before_edge: got %h want 7", an_o); else pass_cnt++;
        step();
        total_cnt++;
        if (an_o !== 4'hF || seg_o !== 7'h7F || ready_o !== 1'b1)
            $display("FAIL dis_idle: got an=%h seg=%h ready=%b want F/7F/1", an_o, seg_o, ready_o);
        else pass_cnt++;
        step();
        total_cnt++;
        if (an_o !== 4'hF) $display("FAIL dis_stay_idle: got %h want F", an_o); else pass_cnt++;
        en_i = 1'b1;
        step();
        total_cnt++;
        if (an_o !== 4'hE || seg_o !== 7'h21)
            $display("FAIL dis_restart: got an=%h seg=%h want E/21", an_o, seg_o);
        else pass_cnt++;
        repeat (4) step();
        total_cnt++;
        if (an_o !== 4'hD || seg_o !== 7'h46)
            $display("FAIL dis_restart_d1: got an=%h seg=%h want D/46", an_o, seg_o);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        step();
        #3;
        rst_ni = 1'b0;
        #1;
        total_cnt++;
        if (an_o !== 4'hF || seg_o !== 7'h7F || ready_o !== 1'b1)
            $display("FAIL arst_immediate: got an=%h seg=%h ready=%b want F/7F/1",
                     an_o, seg_o, ready_o);
        else pass_cnt++;
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (3) step();
        total_cnt++;
        if (an_o !== 4'hF) $display("FAIL arst_stay_idle: got %h want F", an_o); else pass_cnt++;
        blank_lz_i = 1'b1;
        data_i     = 16'h000F;
        valid_i    = 1'b1;
        step();
        valid_i = 1'b0;
        step();
        total_cnt++;
        if (an_o !== 4'hE || seg_o !== 7'h0E)
            $display("FAIL arst_reload_d0: got an=%h seg=%h want E/0E", an_o, seg_o);
        else pass_cnt++;
        repeat (4) step();
        total_cnt++;
        if (an_o !== 4'hF || seg_o !== 7'h7F)
            $display("FAIL arst_reload_d1: got an=%h seg=%h want F/7F", an_o, seg_o);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blank();
        test_pending();
        test_disable();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/hex_scan_ctrl.md
HEX_SCAN_CTRL -- requirements
Module: hex_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, default 8: number of multiplexed 7-segment digits, legal range 2..8.
REQ-002 Parameter DIV, default 50000: clock cycles each digit is driven, legal range 2..2^20.
REQ-003 clk_i  input  1  single block clock, all state updates on its rising edge.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 data_i  input  4*NUM_DIGITS  hex value to display, nibble k drives digit k, with digit 0 least significant.
REQ-006 valid_i  input  1  data_i offered for load.
REQ-007 ready_o  output  1  block accepts data_i; a load occurs on a cycle where valid_i and ready_o are both high.
REQ-008 en_i  input  1  display enable.
REQ-009 blank_lz_i  input  1  leading-zero blanking enable.
REQ-010 seg_o  output  7  active-low segments, bit 6 = g ... bit 0 = a.
REQ-011 an_o  output  NUM_DIGITS  active-low digit selects, at most one low.

Function
REQ-012 State: IDLE, SCAN; registers disp_q (displayed value), pend_q (pending value), pend_vld_q, have_data_q, digit_q, cnt_q.
REQ-013 IDLE: an_o all ones, seg_o 7'h7F, ready_o 1; a load writes disp_q directly and sets have_data_q.
REQ-014 IDLE -> SCAN when en_i=1 and have_data_q=1, with digit_q=0 and cnt_q=0 on entry.
REQ-015 SCAN -> IDLE on the next clock whenever en_i=0; disp_q, pend_q and pend_vld_q retained.
REQ-016 SCAN: ready_o = !pend_vld_q; a load writes pend_q and sets pend_vld_q, disp_q unchanged.
REQ-017 Prescaler: cnt_q counts 0..DIV-1, tick when cnt_q==DIV-1, then wraps to 0.
REQ-018 On tick digit_q advances by 1, wrapping from NUM_DIGITS-1 to 0 (frame end).
REQ-019 At frame end with pend_vld_q=1: disp_q <= pend_q and pend_vld_q cleared in the same edge, so the new value first appears on digit 0 (no tearing).
REQ-020 The SCAN outputs below are combinational from registered state.
REQ-021 In SCAN, an_o bit digit_q is low and all other an_o bits are high.
REQ-022 In SCAN, seg_o shows the decode of disp_q nibble digit_q.
REQ-023 Decode (nibble -> seg_o): 0->40, 1->79, 2->24, 3->30, 4->19, 5->12, 6->02, 7->58, 8->00, 9->18, A->08, B->03, C->46, D->21, E->06, F->0E (hex).
REQ-024 Leading-zero blank: with blank_lz_i=1, digit k>0 is blanked when nibbles k..NUM_DIGITS-1 of disp_q are all zero.
REQ-025 Digit 0 is never blanked.
REQ-026 A blanked digit drives its an_o bit high and seg_o 7'h7F; scan timing is unchanged.
REQ-027 blank_lz_i is sampled combinationally and may change at any time.
REQ-028 Load and frame end on the same edge cannot coincide with pend_vld_q=1, because ready_o is 0 then.
REQ-029 When pend_vld_q=0 on that edge, the load goes to pend_q and is promoted at the next frame end.

Reset
REQ-030 While rst_ni=0: state IDLE; disp_q, pend_q, digit_q, cnt_q zero; pend_vld_q and have_data_q 0.
REQ-031 While rst_ni=0 the outputs are: an_o all ones, seg_o 7'h7F, ready_o 1.
REQ-032 Reset asserted mid-SCAN forces the outputs above immediately, without waiting for a clock edge.

Verification
REQ-033 NUM_DIGITS=4, DIV=4: load 16'h1234 in IDLE with en_i=1. Required response: an_o cycles E,D,B,7 every 4 clocks. seg_o cycles 19,30,24,79 (digit 0 shows 4).
REQ-034 blank_lz_i=1, load 16'h0050. Required response: digits 2,3 have an_o high and seg_o 7F. Digit 1 shows 12 and digit 0 shows 40. With 16'h0000 only digit 0 shows 40.
REQ-035 Mid-frame load 16'hABCD during SCAN. Required response: ready_o drops the next cycle. Old value completes the frame; digit 0 of the next frame shows 21. ready_o returns to 1 on the same edge.
REQ-036 Second valid_i while pend_vld_q=1. Required response: not accepted, pend_q unchanged.
REQ-037 Drop en_i mid-SCAN. Required response: next clock an_o all ones and seg_o 7F. Raising en_i restarts at digit 0 with the retained value.
REQ-038 Assert rst_ni=0 asynchronously mid-digit. Required response: outputs reach reset values before the next edge. The block stays IDLE after release until a new load.
